data_mem_hs: RTL and testbench

- Parametrised successor to the core's single-cycle data memory in the MEM stage.
- Byte-addressed, word-organised single-port RAM.
- Adds:
  - req/ready/done handshake with configurable access latency (wait-states);
  - RV32 load/store width and sign handling from the funct3-encoded mem_len;
  - misalignment and illegal-width error reporting.
- Lets the pipeline stall on a slow memory without changing the MEM-stage interface semantics.

---
 rtl/data_mem_hs.sv | 159 +++++++++++++++
 tb/tb_data_mem_hs.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_hs.sv
// data_mem_hs: byte-addressed, word-organised data RAM for the MEM stage with a
// req/ready/done handshake, configurable access latency and RV32 width handling.
module data_mem_hs #(
   parameter int  DEPTH   = 64,
   parameter int  LATENCY = 1,
   localparam int AW      = $clog2(DEPTH * 4)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [2:0]    mem_len,
   input  logic [31:0]   wdata,
   output logic          ready,
   output logic          done,
   output logic [31:0]   rdata,
   output logic          err
);
   localparam int WW     = AW - 2;
   localparam int CW     = $clog2(LATENCY) + 1;
   localparam bit SINGLE = (LATENCY == 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   pend_rdata_q;
   logic          pend_err_q, pend_ld_q;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          accept, fin;
   logic          bad_len, misalign, fault;
   logic [WW-1:0] widx;
   logic [31:0]   word, ld_val, ld_res, wword;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [3:0]    be;
   logic [31:0]   fin_rdata;
   logic          fin_err, fin_ld;

   assign ready  = (state_q == IDLE);
   assign accept = req && ready;
   assign widx   = addr[AW-1:2];
   assign word   = mem[widx];

   assign ld_byte = word[8*addr[1:0] +: 8];
   assign ld_half = word[16*addr[1] +: 16];

   // Width legality and alignment; either one faults the access.
   always_comb begin
      if (we) bad_len = mem_len[2] || (mem_len[1:0] == 2'b11);
      else    bad_len = (mem_len[1:0] == 2'b11) || (mem_len == 3'b110);
      case (mem_len[1:0])
         2'b01:   misalign = addr[0];
         2'b10:   misalign = |addr[1:0];
         default: misalign = 1'b0;
      endcase
      fault = bad_len || misalign;
   end

   always_comb begin
      case (mem_len)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_val = {24'd0, ld_byte};
         3'b101:  ld_val = {16'd0, ld_half};
         default: ld_val = word;
      endcase
      ld_res = fault ? 32'd0 : ld_val;
   end

   // Narrow stores replicate their data so each lane picks it up in place.
   always_comb begin
      case (mem_len[1:0])
         2'b00: begin
            be    = 4'b0001 << addr[1:0];
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wword = wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && accept && we && !fault)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
   end

   // With a single cycle of latency the result is registered straight from
   // the accept edge; otherwise it comes from the values latched at accept.
   assign fin       = SINGLE ? accept : (state_q == WAIT && cnt_q == CW'(1));
   assign fin_rdata = SINGLE ? ld_res : pend_rdata_q;
   assign fin_err   = SINGLE ? fault  : pend_err_q;
   assign fin_ld    = SINGLE ? !we    : pend_ld_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept && !SINGLE) begin
               state_d = WAIT;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done_d  = fin;
      err_d   = fin && fin_err;
      rdata_d = (fin && fin_ld) ? fin_rdata : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pend_rdata_q <= '0;
         pend_err_q   <= 1'b0;
         pend_ld_q    <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            pend_rdata_q <= ld_res;
            pend_err_q   <= fault;
            pend_ld_q    <= !we;
         end
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: three instances (latency 1, 2, 3) sharing one clock,
// a vector table on the latency-1 instance and scoreboarded completions.
module tb_data_mem_hs;
   localparam int N = 3;

   logic              clk, rst_n;
   logic [N-1:0]      req, we, ready, done, err;
   logic [7:0]        addr  [N];
   logic [2:0]        len   [N];
   logic [31:0]       wdata [N];
   logic [31:0]       rdata [N];

   typedef struct {
      int          k;
      logic [31:0] rd;
      logic        er;
   } exp_t;

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [2:0]  l;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   exp_t sbq[$];
   vec_t tv[$];
   exp_t mon_e;
   int   n_chk = 0, n_pass = 0;
   int   done_cnt [N];
   int   dc0;

   data_mem_hs #(.DEPTH(64), .LATENCY(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .mem_len(len[0]), .wdata(wdata[0]), .ready(ready[0]), .done(done[0]),
      .rdata(rdata[0]), .err(err[0]));

   data_mem_hs #(.DEPTH(64), .LATENCY(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .mem_len(len[1]), .wdata(wdata[1]), .ready(ready[1]), .done(done[1]),
      .rdata(rdata[1]), .err(err[1]));

   data_mem_hs #(.DEPTH(64), .LATENCY(3)) u_l3 (
      .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]), .addr(addr[2]),
      .mem_len(len[2]), .wdata(wdata[2]), .ready(ready[2]), .done(done[2]),
      .rdata(rdata[2]), .err(err[2]));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   // Completion monitor: every done pops the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (done[k]) begin
            done_cnt[k]++;
            n_chk++;
            if (sbq.size() == 0) begin
               $display("FAIL unexpected_done: inst %0d pulsed done with nothing outstanding", k);
            end else begin
               n_pass++;
               mon_e = sbq.pop_front();
               chk("done_inst", k, mon_e.k);
               chk("rdata", rdata[k], mon_e.rd);
               chk("err", {31'd0, err[k]}, {31'd0, mon_e.er});
            end
         end else begin
            chk("err_without_done", {31'd0, err[k]}, 32'd0);
         end
      end
   end

   task automatic drive(input int k, input logic w, input logic [7:0] a,
                        input logic [2:0] l, input logic [31:0] wd);
      we[k] = w; addr[k] = a; len[k] = l; wdata[k] = wd; req[k] = 1'b1;
   endtask

   task automatic push(input int k, input logic [31:0] rd, input logic er);
      sbq.push_back(exp_t'{k, rd, er});
   endtask

   // Called at a negedge; holds req until accepted, returns at a later negedge.
   task automatic issue(input int k, input logic w, input logic [7:0] a, input logic [2:0] l,
                        input logic [31:0] wd, input logic [31:0] rd, input logic er);
      bit ok = 1'b0;
      drive(k, w, a, l, wd);
      for (int t = 0; t < 20 && !ok; t++) begin
         if (ready[k]) begin
            push(k, rd, er);
            ok = 1'b1;
            @(posedge clk);
         end
         @(negedge clk);
      end
      req[k] = 1'b0;
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL issue_timeout: inst %0d ready stayed low", k);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (sbq.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sbq.size(), 0);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      req = '0; we = '0;
      for (int k = 0; k < N; k++) begin
         addr[k] = '0; len[k] = '0; wdata[k] = '0; done_cnt[k] = 0;
      end

      //                w     addr   len     wdata          rdata          err
      tv.push_back(vec_t'{1'b1, 8'h98, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h98, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
      tv.push_back(vec_t'{1'b1, 8'h80, 3'b010, 32'h11223344, 32'hDEADBEEF, 1'b0});
      tv.push_back(vec_t'{1'b1, 8'h81, 3'b000, 32'h000000AB, 32'hDEADBEEF, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b010, 32'h0,        32'h1122AB44, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h81, 3'b000, 32'h0,        32'hFFFFFFAB, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h81, 3'b100, 32'h0,        32'h000000AB, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h82, 3'b001, 32'h0,        32'h00001122, 1'b0});
      tv.push_back(vec_t'{1'b1, 8'h82, 3'b001, 32'h0000F00D, 32'h00001122, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h82, 3'b001, 32'h0,        32'hFFFFF00D, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h82, 3'b101, 32'h0,        32'h0000F00D, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h99, 3'b010, 32'h0,        32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b1, 8'h83, 3'b001, 32'h0000FFFF, 32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b010, 32'h0,        32'hF00DAB44, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b011, 32'h0,        32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b1, 8'h80, 3'b100, 32'h0,        32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b010, 32'h0,        32'hF00DAB44, 1'b0});
      tv.push_back(vec_t'{1'b1, 8'h80, 3'b011, 32'h0,        32'hF00DAB44, 1'b1});
      tv.push_back(vec_t'{1'b0, 8'h83, 3'b000, 32'h0,        32'hFFFFFFF0, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b101, 32'h0,        32'h0000AB44, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h81, 3'b001, 32'h0,        32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b1, 8'h82, 3'b010, 32'h0,        32'h00000000, 1'b1});
      tv.push_back(vec_t'{1'b0, 8'h98, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
      tv.push_back(vec_t'{1'b1, 8'h83, 3'b000, 32'h12345677, 32'hDEADBEEF, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h83, 3'b000, 32'h0,        32'h00000077, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b010, 32'h0,        32'h770DAB44, 1'b0});
      tv.push_back(vec_t'{1'b0, 8'h80, 3'b111, 32'h0,        32'h00000000, 1'b1});

      #12;
      for (int k = 0; k < N; k++) begin
         chk("rst_ready", {31'd0, ready[k]}, 32'd1);
         chk("rst_done",  {31'd0, done[k]},  32'd0);
         chk("rst_err",   {31'd0, err[k]},   32'd0);
         chk("rst_rdata", rdata[k], 32'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Latency 1: back-to-back table, ready must never drop.
      foreach (tv[i]) begin
         chk("l1_ready", {31'd0, ready[0]}, 32'd1);
         issue(0, tv[i].w, tv[i].a, tv[i].l, tv[i].wd, tv[i].rd, tv[i].er);
      end
      wait_idle();

      // Latency 2: new request accepted in the done cycle.
      issue(1, 1'b1, 8'h40, 3'b010, 32'hA5A50001, 32'h0, 1'b0);
      issue(1, 1'b1, 8'h44, 3'b010, 32'h5A5A0002, 32'h0, 1'b0);
      wait_idle();
      drive(1, 1'b0, 8'h40, 3'b010, 32'h0);
      chk("b2b_ready0", {31'd0, ready[1]}, 32'd1);
      push(1, 32'hA5A50001, 1'b0);
      @(negedge clk);
      chk("b2b_busy",  {31'd0, ready[1]}, 32'd0);
      chk("b2b_nodone", {31'd0, done[1]}, 32'd0);
      @(negedge clk);
      chk("b2b_done1", {31'd0, done[1]}, 32'd1);
      chk("b2b_ready1", {31'd0, ready[1]}, 32'd1);
      drive(1, 1'b0, 8'h44, 3'b010, 32'h0);
      push(1, 32'h5A5A0002, 1'b0);
      @(negedge clk);
      req[1] = 1'b0;
      chk("b2b_gap_done", {31'd0, done[1]}, 32'd0);
      chk("b2b_gap_busy", {31'd0, ready[1]}, 32'd0);
      @(negedge clk);
      chk("b2b_done2", {31'd0, done[1]}, 32'd1);
      wait_idle();

      // Latency 3: req held high throughout, exactly one accept.
      issue(2, 1'b1, 8'h20, 3'b010, 32'h13572468, 32'h0, 1'b0);
      wait_idle();
      dc0 = done_cnt[2];
      drive(2, 1'b0, 8'h20, 3'b010, 32'h0);
      chk("l3_ready_e0", {31'd0, ready[2]}, 32'd1);
      push(2, 32'h13572468, 1'b0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("l3_busy",   {31'd0, ready[2]}, 32'd0);
         chk("l3_nodone", {31'd0, done[2]},  32'd0);
      end
      @(negedge clk);
      chk("l3_done",  {31'd0, done[2]},  32'd1);
      chk("l3_ready", {31'd0, ready[2]}, 32'd1);
      req[2] = 1'b0;
      repeat (4) @(negedge clk);
      chk("l3_one_done", done_cnt[2] - dc0, 32'd1);

      // Latency 3: reset while a store is in WAIT.
      drive(2, 1'b1, 8'h10, 3'b010, 32'hCAFEF00D);
      chk("rw_ready", {31'd0, ready[2]}, 32'd1);
      push(2, 32'h13572468, 1'b0);
      @(posedge clk);
      @(negedge clk);
      req[2] = 1'b0;
      chk("rw_busy", {31'd0, ready[2]}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_rst_ready", {31'd0, ready[2]}, 32'd1);
      chk("rw_rst_done",  {31'd0, done[2]},  32'd0);
      chk("rw_rst_err",   {31'd0, err[2]},   32'd0);
      chk("rw_rst_rdata", rdata[2], 32'd0);
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2, 1'b0, 8'h10, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
